// File: rtl/decimal_pkg.sv
// Shared decimal-conversion definitions: FSM states, the digit-count to
// binary-width mapping and the double-dabble adjust constant.
package decimal_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [3:0] ADJ = 4'd3;

  // Binary width needed to hold (10^ndig)-1.
  function automatic int bw_for(input int ndig);
    case (ndig)
      1:       return 4;
      2:       return 7;
      3:       return 10;
      4:       return 14;
      default: return 14;
    endcase
  endfunction

endpackage

// File: rtl/bcd_adj_nibble.sv
// One BCD digit correction cell for reverse double dabble:
// a nibble of 8 or more after the right shift has 3 subtracted.
module bcd_adj_nibble
  import decimal_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd8) ? (din - ADJ) : din;

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter using reverse double dabble,
// one shift/adjust iteration per clock, BW iterations per conversion.
module bcd_to_bin_seq
  import decimal_pkg::*;
#(
  parameter  int NDIG = 3,
  localparam int BW   = bw_for(NDIG)
) (
  input  logic              CLOCK_50,
  input  logic              RST,
  input  logic              start,
  input  logic [4*NDIG-1:0] bcd_in,
  output logic              busy,
  output logic              done,
  output logic [BW-1:0]     bin_out,
  output logic              err
);

  localparam int DW = 4 * NDIG;
  localparam int CW = $clog2(BW + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BW);

  state_t        state_reg, state_next;
  logic [DW-1:0] bcd_reg, bcd_next;
  logic [BW-1:0] bin_reg, bin_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [BW-1:0] bin_out_reg, bin_out_next;
  logic          err_reg, err_next;

  logic [DW+BW-1:0] shifted;
  logic [DW-1:0]    bcd_adj;
  logic [NDIG-1:0]  dig_ok;
  logic             in_valid;
  logic [CW-1:0]    cnt_inc;

  assign shifted = {bcd_reg, bin_reg} >> 1;

  generate
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
      bcd_adj_nibble u_adj (
        .din  (shifted[BW + 4*gi +: 4]),
        .dout (bcd_adj[4*gi +: 4])
      );
      assign dig_ok[gi] = (bcd_in[4*gi +: 4] <= 4'd9);
    end
  endgenerate

  assign in_valid = &dig_ok;
  // Saturating increment: the counter can never wrap past BW.
  assign cnt_inc  = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;

  always_ff @(posedge CLOCK_50) begin
    if (RST) begin
      state_reg   <= IDLE;
      bcd_reg     <= '0;
      bin_reg     <= '0;
      cnt_reg     <= '0;
      bin_out_reg <= '0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      bcd_reg     <= bcd_next;
      bin_reg     <= bin_next;
      cnt_reg     <= cnt_next;
      bin_out_reg <= bin_out_next;
      err_reg     <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    bcd_next     = bcd_reg;
    bin_next     = bin_reg;
    cnt_next     = cnt_reg;
    bin_out_next = bin_out_reg;
    err_next     = err_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          bcd_next = bcd_in;
          bin_next = '0;
          cnt_next = '0;
          if (in_valid) begin
            state_next = RUN;
          end else begin
            // Bad digit: report immediately, keep the previous result.
            state_next = FIN;
            err_next   = 1'b1;
          end
        end
      end
      RUN: begin
        bcd_next = bcd_adj;
        bin_next = shifted[BW-1:0];
        cnt_next = cnt_inc;
        if (cnt_inc == CNT_MAX) begin
          state_next   = FIN;
          bin_out_next = shifted[BW-1:0];
          err_next     = 1'b0;
        end
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy    = (state_reg != IDLE);
  assign done    = (state_reg == FIN);
  assign bin_out = bin_out_reg;
  assign err     = err_reg;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Self-checking bench: NDIG=3 instance checked every cycle against a latency
// and decimal-arithmetic model, plus directed checks on an NDIG=4 instance.
module tb_bcd_to_bin_seq;

  localparam int BW3 = 10;
  localparam int BW4 = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, start4;
  logic [11:0] bcd;
  logic [15:0] bcd4;
  logic        busy, done, err, busy4, done4, err4;
  logic [9:0]  bin;
  logic [13:0] bin4;

  int  errors = 0;
  int  checks = 0;
  bit  cmp_en = 0;

  bcd_to_bin_seq #(.NDIG(3)) dut3 (
    .CLOCK_50 (clk), .RST (rst), .start (start), .bcd_in (bcd),
    .busy (busy), .done (done), .bin_out (bin), .err (err)
  );

  bcd_to_bin_seq #(.NDIG(4)) dut4 (
    .CLOCK_50 (clk), .RST (rst), .start (start4), .bcd_in (bcd4),
    .busy (busy4), .done (done4), .bin_out (bin4), .err (err4)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  function automatic bit bcd_ok(input logic [15:0] v, input int nd);
    for (int i = 0; i < nd; i++)
      if (((v >> (4*i)) & 16'hF) > 16'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd_val(input logic [15:0] v, input int nd);
    int r = 0;
    for (int i = nd - 1; i >= 0; i--) r = r * 10 + int'((v >> (4*i)) & 16'hF);
    return r;
  endfunction

  function automatic logic [15:0] rand_bcd(input int nd, input bit allow_bad);
    logic [15:0] v = '0;
    for (int i = 0; i < nd; i++) begin
      if (allow_bad && $urandom_range(0, 7) == 0)
        v[4*i +: 4] = 4'($urandom_range(10, 15));
      else
        v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  // Model: busy cycles remaining after an accepted request, and the result
  // that becomes visible in the final (done) cycle.
  int m_rem = 0, m_bin = 0, m_pend = 0;
  bit m_err = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_rem = 0; m_bin = 0; m_err = 0;
    end else if (m_rem == 0) begin
      if (start) begin
        if (bcd_ok(16'(bcd), 3)) begin
          m_rem  = BW3 + 1;
          m_pend = bcd_val(16'(bcd), 3);
        end else begin
          m_rem = 1;
          m_err = 1;
        end
      end
    end else begin
      m_rem--;
      if (m_rem == 1) begin
        m_bin = m_pend;
        m_err = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_busy", busy, 32'(m_rem != 0));
      chk("model_done", done, 32'(m_rem == 1));
      chk("model_bin_out", bin, m_bin);
      chk("model_err", err, 32'(m_err));
      if (done) $display("txn: bin_out=%0d err=%0b", bin, err);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 30 && (busy || busy4); k++) tick();
    if (busy || busy4) chk("idle_timeout", 1, 0);
  endtask

  task automatic convert3(input logic [11:0] v, output int edges, output int bcnt);
    start = 1'b1; bcd = v;
    tick();
    start = 1'b0; bcd = 12'($urandom);
    edges = 1; bcnt = busy ? 1 : 0;
    while (!done && edges < 40) begin
      tick(); edges++;
      if (busy) bcnt++;
    end
    if (!done) chk("done_timeout3", 0, 1);
  endtask

  task automatic convert4(input logic [15:0] v, output int edges);
    start4 = 1'b1; bcd4 = v;
    tick();
    start4 = 1'b0; bcd4 = 16'($urandom);
    edges = 1;
    while (!done4 && edges < 40) begin
      tick(); edges++;
    end
    if (!done4) chk("done_timeout4", 0, 1);
  endtask

  initial begin
    int edges, bcnt, t1, t2, dcnt;
    logic [15:0] v;

    rst = 1'b1; start = 1'b0; start4 = 1'b0; bcd = '0; bcd4 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bin", bin, 0);
    chk("rst_err", err, 0);
    chk("rst_bin4", bin4, 0);
    rst = 1'b0;
    cmp_en = 1;

    chk("pin_model_999", bcd_val(16'h0999, 3), 999);
    chk("pin_model_bad", 32'(bcd_ok(16'h01A5, 3)), 0);

    convert3(12'h999, edges, bcnt);
    chk("c999_edges", edges, 11);
    chk("c999_busy_cycles", bcnt, 11);
    chk("c999_bin", bin, 32'h3E7);
    chk("c999_err", err, 0);
    tick();
    chk("c999_idle", busy, 0);

    convert3(12'h042, edges, bcnt);
    chk("c042_bin", bin, 42);
    tick();
    convert3(12'h1A5, edges, bcnt);
    chk("c1A5_edges", edges, 1);
    chk("c1A5_err", err, 1);
    chk("c1A5_bin_kept", bin, 42);
    tick();
    convert3(12'h000, edges, bcnt);
    chk("c000_bin", bin, 0);
    chk("c000_err", err, 0);
    tick();

    // Start held high: back-to-back conversions spaced by BW+2 cycles.
    start = 1'b1; bcd = 12'h123; t1 = -1; t2 = -1;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done) begin
        chk("b2b_bin", bin, 123);
        if (t1 < 0) t1 = k;
        else if (t2 < 0) t2 = k;
      end
    end
    start = 1'b0;
    chk("b2b_gap", t2 - t1, 12);
    wait_idle();

    // Reset 5 cycles into RUN aborts without a done pulse.
    start = 1'b1; bcd = 12'h999;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    chk("abort_busy", busy, 0);
    chk("abort_bin", bin, 0);
    chk("abort_err", err, 0);
    chk("abort_done", done, 0);
    rst = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);

    // Reset wins over start at the same edge.
    rst = 1'b1; start = 1'b1; bcd = 12'h321;
    tick();
    chk("rst_prio_busy", busy, 0);
    rst = 1'b0; start = 1'b0;
    tick();
    chk("rst_prio_idle", busy, 0);

    convert4(16'h9999, edges);
    chk("c9999_edges", edges, 15);
    chk("c9999_bin", bin4, 32'h270F);
    chk("c9999_err", err4, 0);
    tick();
    for (int n = 0; n < 6; n++) begin
      v = rand_bcd(4, 1'b1);
      convert4(v, edges);
      chk("c4_edges", edges, bcd_ok(v, 4) ? BW4 + 1 : 1);
      chk("c4_err", err4, 32'(!bcd_ok(v, 4)));
      if (bcd_ok(v, 4)) chk("c4_bin", bin4, bcd_val(v, 4));
      tick();
    end

    // Random traffic on the NDIG=3 instance, including starts while busy.
    for (int k = 0; k < 600; k++) begin
      start = ($urandom_range(0, 2) == 0);
      bcd   = 12'(rand_bcd(3, 1'b1));
      rst   = ($urandom_range(0, 149) == 0);
      tick();
    end
    start = 1'b0; rst = 1'b0;
    wait_idle();
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
